uart_cmd_decoder: RTL and testbench

Host-command responder between the UART byte receiver/transmitter and the system memory bus of the NES FPGA top level. Parses the byte-serial command stream from the debug host (write byte, read byte, CPU hold, CPU run), issues single-cycle memory bus strobes, and returns read data through the UART transmitter. All program-ROM and CHR loading and readback, plus CPU hold/release, pass through this block.

---
 rtl/ie_defs.sv | 35 +++
 rtl/uart_cmd_timer.sv | 42 ++++
 rtl/uart_cmd_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ie_defs.sv
// ie_defs: shared definitions for the NES FPGA top-level infrastructure blocks.
//
// Contents used by uart_cmd_decoder:
//   CMD_WRITE / CMD_READ / CMD_CPU_HOLD / CMD_CPU_RUN  host opcode bytes
//   uart_cmd_state_t                                   command decoder FSM states
//   is_timed_state()                                   states in which the optional
//                                                      inter-byte / read timer runs

package ie_defs;

    // Host command opcodes (first byte of every command)
    localparam logic [7:0] CMD_WRITE    = 8'h02;
    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_CPU_HOLD = 8'h06;
    localparam logic [7:0] CMD_CPU_RUN  = 8'h07;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR_HI  = 4'd1,
        ADDR_LO  = 4'd2,
        DATA     = 4'd3,
        WR_ISSUE = 4'd4,
        RD_ISSUE = 4'd5,
        RD_WAIT  = 4'd6,
        TX_SEND  = 4'd7,
        TX_WAIT  = 4'd8
    } uart_cmd_state_t;

    // States that wait on something outside the block (host bytes or bus read
    // data) and may therefore be bounded by the timeout counter.
    function automatic logic is_timed_state(input uart_cmd_state_t s);
        return (s == ADDR_HI) || (s == ADDR_LO) || (s == DATA) || (s == RD_WAIT);
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: loadable down-counter used as the command timeout.
//
// While clr is high the counter reloads LOAD_VALUE. While en is high (and clr
// low) it counts down and stops at zero. expire is high in any enabled,
// non-cleared cycle where the count has reached zero, so an event that clears
// the counter in the same cycle always wins over expiry.
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset (count := LOAD_VALUE)
//   clr     in   reload the counter
//   en      in   count down
//   expire  out  count exhausted while enabled

module uart_cmd_timer #(
    parameter int unsigned LOAD_VALUE = 99,
    parameter int unsigned COUNT_W    = (LOAD_VALUE > 1) ? $clog2(LOAD_VALUE + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [COUNT_W-1:0] LOAD_CNT = COUNT_W'(LOAD_VALUE);

    logic [COUNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= LOAD_CNT;
        end else if (clr) begin
            count_reg <= LOAD_CNT;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = en && !clr && (count_reg == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: host-command responder between the UART byte receiver /
// transmitter and the system memory bus.
//
// Command stream (one byte per rx_valid pulse):
//   02 addr_hi addr_lo data   single-byte bus write
//   03 addr_hi addr_lo        single-byte bus read, result returned on the UART
//   06                        cpu_hold := 1
//   07                        cpu_hold := 0
//   anything else in IDLE     cmd_err pulse
//
// Build option: define CMD_TIMEOUT_EN to bound the inter-byte gap of a partial
// command and the wait for read data by TIMEOUT_CYCLES clocks. Without it, a
// partial command and a pending read wait indefinitely.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rx_valid, rx_data   received byte strobe and value
//   tx_start, tx_data   transmit request pulse and byte (held until next read)
//   tx_active           transmitter busy
//   mem_addr, mem_wdata bus address / write data (held until the next command)
//   mem_we, mem_re      one-cycle write / read strobes
//   mem_rdata, mem_rvalid  read data and its valid pulse
//   cpu_hold            level, holds the CPU/PPU in reset
//   busy                FSM is not in IDLE
//   cmd_err             one-cycle pulse on unknown opcode or timeout

import ie_defs::*;

module uart_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_active,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic        cpu_hold,
    output logic        busy,
    output logic        cmd_err
);

    uart_cmd_state_t state_reg, state_next;
    logic [15:0]     addr_reg, addr_next;
    logic [7:0]      wdata_reg, wdata_next;
    logic [7:0]      tx_data_reg, tx_data_next;
    logic            op_read_reg, op_read_next;
    logic            cpu_hold_reg, cpu_hold_next;
    logic            cmd_err_reg, cmd_err_next;
    // High during the first TX_WAIT cycle: the transmitter may not have raised
    // tx_active yet in response to tx_start, so it is not looked at then.
    logic            guard_reg;
    logic            timer_expire;

`ifdef CMD_TIMEOUT_EN
    logic timer_en;
    logic timer_clr;

    // Host bytes restart the inter-byte window; bytes arriving during RD_WAIT
    // are dropped and must not extend the wait for read data.
    assign timer_en  = is_timed_state(state_reg);
    assign timer_clr = !timer_en || (rx_valid && (state_reg != RD_WAIT));

    uart_cmd_timer #(
        .LOAD_VALUE ((TIMEOUT_CYCLES > 1) ? (TIMEOUT_CYCLES - 1) : 1)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );
`else
    // Timer compiled out: it can never fire. The comparison only keeps the
    // parameter referenced so both builds share one interface.
    assign timer_expire = (TIMEOUT_CYCLES < 0);
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            tx_data_reg  <= '0;
            op_read_reg  <= 1'b0;
            cpu_hold_reg <= 1'b0;
            cmd_err_reg  <= 1'b0;
            guard_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            tx_data_reg  <= tx_data_next;
            op_read_reg  <= op_read_next;
            cpu_hold_reg <= cpu_hold_next;
            cmd_err_reg  <= cmd_err_next;
            guard_reg    <= (state_reg == TX_SEND);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        tx_data_next  = tx_data_reg;
        op_read_next  = op_read_reg;
        cpu_hold_next = cpu_hold_reg;
        cmd_err_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_WRITE: begin
                            op_read_next = 1'b0;
                            state_next   = ADDR_HI;
                        end
                        CMD_READ: begin
                            op_read_next = 1'b1;
                            state_next   = ADDR_HI;
                        end
                        CMD_CPU_HOLD: cpu_hold_next = 1'b1;
                        CMD_CPU_RUN:  cpu_hold_next = 1'b0;
                        default:      cmd_err_next  = 1'b1;
                    endcase
                end
            end

            ADDR_HI: begin
                if (rx_valid) begin
                    addr_next[15:8] = rx_data;
                    state_next      = ADDR_LO;
                end else if (timer_expire) begin
                    cmd_err_next = 1'b1;
                    state_next   = IDLE;
                end
            end

            ADDR_LO: begin
                if (rx_valid) begin
                    addr_next[7:0] = rx_data;
                    state_next     = op_read_reg ? RD_ISSUE : DATA;
                end else if (timer_expire) begin
                    cmd_err_next = 1'b1;
                    state_next   = IDLE;
                end
            end

            DATA: begin
                if (rx_valid) begin
                    wdata_next = rx_data;
                    state_next = WR_ISSUE;
                end else if (timer_expire) begin
                    cmd_err_next = 1'b1;
                    state_next   = IDLE;
                end
            end

            WR_ISSUE: state_next = IDLE;

            RD_ISSUE: state_next = RD_WAIT;

            RD_WAIT: begin
                if (mem_rvalid) begin
                    tx_data_next = mem_rdata;
                    state_next   = TX_SEND;
                end else if (timer_expire) begin
                    // The host is still expecting one byte back, so answer
                    // with a marker value rather than going silent.
                    tx_data_next = 8'hFF;
                    cmd_err_next = 1'b1;
                    state_next   = TX_SEND;
                end
            end

            TX_SEND: state_next = TX_WAIT;

            TX_WAIT: begin
                if (!guard_reg && !tx_active) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so each is high for
    // exactly the one cycle spent in its issue state.
    assign mem_we    = (state_reg == WR_ISSUE);
    assign mem_re    = (state_reg == RD_ISSUE);
    assign tx_start  = (state_reg == TX_SEND);
    assign busy      = (state_reg != IDLE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign tx_data   = tx_data_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign cmd_err   = cmd_err_reg;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed self-checking bench for uart_cmd_decoder.
// Drives host bytes, emulates the bus read response and the transmitter busy
// flag, and checks outputs one cycle at a time against hand-computed values.

`timescale 1ns/1ps

module tb_uart_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_active = 1'b0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_rvalid = 1'b0;
    logic        cpu_hold;
    logic        busy;
    logic        cmd_err;

    int checks = 0;
    int failures = 0;

    // Strobe pulse counters, sampled at each rising edge
    int we_cnt = 0;
    int re_cnt = 0;
    int txs_cnt = 0;
    int err_cnt = 0;

    uart_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_active  (tx_active),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)   we_cnt++;
        if (mem_re)   re_cnt++;
        if (tx_start) txs_cnt++;
        if (cmd_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-20s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One rx_valid pulse; returns in the cycle after the byte was presented
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        $display("rx byte %02h", b);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_tx_start"},  {31'd0, tx_start},  32'd0);
        chk({tag, "_tx_data"},   {24'd0, tx_data},   32'd0);
        chk({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_we_re"},     {30'd0, mem_we, mem_re}, 32'd0);
        chk({tag, "_cpu_hold"},  {31'd0, cpu_hold},  32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_cmd_err"},   {31'd0, cmd_err},   32'd0);
    endtask

    int base_we, base_re, base_txs, base_err;
    int n;

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("reset");
        rst = 1'b0;
        tick();

        // ---------------- write 02 80 10 A5 ----------------
        base_we = we_cnt;
        send_byte(8'h02);
        chk("wr_busy_after_op", {31'd0, busy}, 32'd1);
        send_byte(8'h80);
        send_byte(8'h10);
        chk("wr_no_we_early", {31'd0, mem_we}, 32'd0);
        send_byte(8'hA5);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", {16'd0, mem_addr}, 32'h8010);
        chk("wr_wdata", {24'd0, mem_wdata}, 32'hA5);
        tick();
        chk("wr_we_drop", {31'd0, mem_we}, 32'd0);
        chk("wr_busy_drop", {31'd0, busy}, 32'd0);
        chk("wr_we_count", we_cnt - base_we, 32'd1);

        // ---------------- read 03 3F 00, rvalid 3 cycles after mem_re ----------------
        base_re = re_cnt;
        base_txs = txs_cnt;
        base_we = we_cnt;
        send_byte(8'h03);
        send_byte(8'h3F);
        send_byte(8'h00);
        chk("rd_re", {31'd0, mem_re}, 32'd1);
        chk("rd_addr", {16'd0, mem_addr}, 32'h3F00);
        tick();
        chk("rd_re_drop", {31'd0, mem_re}, 32'd0);
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h3C;
        chk("rd_no_tx_yet", {31'd0, tx_start}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 8'h00;
        chk("rd_tx_start", {31'd0, tx_start}, 32'd1);
        chk("rd_tx_data", {24'd0, tx_data}, 32'h3C);
        tick();
        // Transmitter starts; an 02 arriving in TX_WAIT must be dropped
        tx_active = 1'b1;
        chk("rd_busy_txwait", {31'd0, busy}, 32'd1);
        tick();
        send_byte(8'h02);
        repeat (3) tick();
        chk("rd_tx_data_hold", {24'd0, tx_data}, 32'h3C);
        tx_active = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("rd_idle_after_tx", {31'd0, busy}, 32'd0);
        chk("rd_re_count", re_cnt - base_re, 32'd1);
        chk("rd_tx_count", txs_cnt - base_txs, 32'd1);

        // ---------------- dropped 02 was ignored: normal read 03 00 00 ----------------
        base_re = re_cnt;
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("rd2_re", {31'd0, mem_re}, 32'd1);
        chk("rd2_addr", {16'd0, mem_addr}, 32'h0000);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 8'h5A;
        tick();
        mem_rvalid = 1'b0;
        chk("rd2_tx_data", {24'd0, tx_data}, 32'h5A);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("rd2_idle", {31'd0, busy}, 32'd0);
        chk("rd2_no_write", we_cnt - base_we, 32'd0);
        chk("rd2_re_count", re_cnt - base_re, 32'd1);

        // ---------------- hold / run ----------------
        base_we = we_cnt;
        base_re = re_cnt;
        send_byte(8'h06);
        chk("hold_set", {31'd0, cpu_hold}, 32'd1);
        chk("hold_idle", {31'd0, busy}, 32'd0);
        tick();
        send_byte(8'h07);
        chk("run_clear", {31'd0, cpu_hold}, 32'd0);
        tick();
        chk("hold_no_strobes", (we_cnt - base_we) + (re_cnt - base_re), 32'd0);

        // ---------------- unknown opcode ----------------
        base_err = err_cnt;
        send_byte(8'h55);
        chk("unk_err", {31'd0, cmd_err}, 32'd1);
        chk("unk_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("unk_err_drop", {31'd0, cmd_err}, 32'd0);
        chk("unk_err_count", err_cnt - base_err, 32'd1);

        // ---------------- reset mid-command (with cpu_hold set) ----------------
        send_byte(8'h06);
        send_byte(8'h02);
        send_byte(8'h12);
        chk("mid_addr_hi", {16'd0, mem_addr}, 32'h1200);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        base_we = we_cnt;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h7E);
        chk("post_rst_we", {31'd0, mem_we}, 32'd1);
        chk("post_rst_addr", {16'd0, mem_addr}, 32'h0001);
        chk("post_rst_wdata", {24'd0, mem_wdata}, 32'h7E);
        tick();
        chk("post_rst_we_count", we_cnt - base_we, 32'd1);

        // ---------------- partial command then silence ----------------
        base_we = we_cnt;
        base_err = err_cnt;
        send_byte(8'h02);
        send_byte(8'h80);
        repeat (120) tick();
        chk("to_no_write", we_cnt - base_we, 32'd0);
`ifdef CMD_TIMEOUT_EN
        chk("to_err_count", err_cnt - base_err, 32'd1);
        chk("to_idle", {31'd0, busy}, 32'd0);
`else
        chk("to_no_err", err_cnt - base_err, 32'd0);
        chk("to_busy_held", {31'd0, busy}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
